// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic, iterative shift-add MUL and restoring DIV.
// Optional zero/neg/ovf flag outputs are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             illegal,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             zero,
    output logic             neg,
    output logic             ovf,
`endif
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
                              OP_XOR, OP_XNOR, OP_ILL} op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             illegal_q, illegal_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;

    op_t              op;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem, div_diff;
    logic             div_ge;

    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign add_res   = a + b;
    assign sub_res   = a - b;

    always_comb begin
        op = OP_ILL;
        if (!aluop[1])
            op = aluop[0] ? OP_SUB : OP_ADD;
        else if (!funct[3])
            op = op_t'({1'b0, funct[2:0]});
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        result_d  = result_q;
        hi_d      = hi_q;
        illegal_d = illegal_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rem   = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_rem - {1'b0, opnd_q};
        div_ge    = (div_rem >= {1'b0, opnd_q});

        case (state_q)
            S_MUL, S_DIV: begin
                // MUL shifts the partial product right; DIV shifts the dividend left into the remainder
                if (state_q == S_MUL) begin
                    {acc_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], div_ge};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_d  = lo_d;
                    hi_d      = acc_d;
                    illegal_d = 1'b0;
                    div0_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                if (state_q == S_DONE)
                    state_d = S_IDLE;
                if (accept) begin
                    illegal_d = 1'b0;
                    div0_d    = 1'b0;
                    hi_d      = '0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                    case (op)
                        OP_ADD:  result_d = add_res;
                        OP_SUB:  result_d = sub_res;
                        OP_AND:  result_d = a & b;
                        OP_OR:   result_d = a | b;
                        OP_XOR:  result_d = a ^ b;
                        OP_XNOR: result_d = ~(a ^ b);
                        OP_MUL: begin
                            done_d  = 1'b0;
                            state_d = S_MUL;
                            opnd_d  = a;
                            lo_d    = b;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                result_d = '1;
                                hi_d     = a;
                                div0_d   = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                state_d = S_DIV;
                                opnd_d  = b;
                                lo_d    = a;
                                acc_d   = '0;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            illegal_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            illegal_q <= illegal_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic ovf_q, ovf_d;
    logic ovf_add, ovf_sub;

    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (done_d) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[WIDTH-1];
            ovf_d  = accept && ((op == OP_ADD && ovf_add) || (op == OP_SUB && ovf_sub));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

    assign busy    = (state_q == S_MUL) || (state_q == S_DIV);
    assign done    = done_q;
    assign result  = result_q;
    assign hi      = hi_q;
    assign illegal = illegal_q;
    assign div0    = div0_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   aluop;
    logic [3:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done, illegal, div0;
    logic [W-1:0] result, hi;
`ifdef ALU_SEQ_FLAGS_EN
    logic         zero, neg, ovf;
`endif

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .hi(hi),
        .illegal(illegal),
`ifdef ALU_SEQ_FLAGS_EN
        .zero(zero), .neg(neg), .ovf(ovf),
`endif
        .div0(div0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        bit           ill;
        bit           d0;
        bit           multi;
        bit           ovf;
    } exp_t;

    exp_t last_e;

    function automatic exp_t model(input logic [1:0] op2, input logic [3:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint p;
        longint s;
        longint lim;
        int     code;
        e.res = '0; e.hi = '0; e.ill = 0; e.d0 = 0; e.multi = 0; e.ovf = 0;
        lim = longint'(1) << (W - 1);
        if (!op2[1])      code = int'(op2[0]);
        else if (fn[3])   code = -1;
        else              code = int'(fn[2:0]);
        case (code)
            0: begin
                s = longint'($signed(x)) + longint'($signed(y));
                e.res = x + y;
                e.ovf = (s >= lim) || (s < -lim);
            end
            1: begin
                s = longint'($signed(x)) - longint'($signed(y));
                e.res = x - y;
                e.ovf = (s >= lim) || (s < -lim);
            end
            2: begin
                p = longint'(x) * longint'(y);
                e.res = p[W-1:0];
                e.hi = p[2*W-1:W];
                e.multi = 1;
            end
            3: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.d0 = 1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.multi = 1;
                end
            end
            4: e.res = x & y;
            5: e.res = x | y;
            6: e.res = x ^ y;
            7: e.res = ~(x ^ y);
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Issues one operation at the current negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] op2, input logic [3:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        exp_t e;
        int   lat;
        e = model(op2, fn, x, y);
        aluop = op2; funct = fn; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 1;
        for (int i = 0; i < W + 4; i++) begin
            if (done) break;
            if (lat == 1) chk({tag, ".busy_run"}, busy, e.multi);
            if (e.multi && lat == 5) begin
                start = 1'b1; aluop = 2'b10; funct = 4'b0100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".latency"}, lat, e.multi ? W + 1 : 1);
        chk({tag, ".busy_done"}, busy, 0);
        chk({tag, ".result"}, result, e.res);
        chk({tag, ".hi"}, hi, e.hi);
        chk({tag, ".illegal"}, illegal, e.ill);
        chk({tag, ".div0"}, div0, e.d0);
`ifdef ALU_SEQ_FLAGS_EN
        chk({tag, ".zero"}, zero, e.res == '0);
        chk({tag, ".neg"}, neg, e.res[W-1]);
        chk({tag, ".ovf"}, ovf, e.ovf);
`endif
        last_e = e;
    endtask

    task automatic idle_chk(input string tag);
        start = 1'b0;
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".result_hold"}, result, last_e.res);
        chk({tag, ".hi_hold"}, hi, last_e.hi);
    endtask

    initial begin
        int seen;
        logic [1:0]   r_op;
        logic [3:0]   r_fn;
        logic [W-1:0] r_a, r_b;
        reset = 1'b1; start = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        chk("rst.hi", hi, 0);
        chk("rst.illegal", illegal, 0);
        chk("rst.div0", div0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 4'b0000, 16'h7FFF, 16'h0001, "add_ovf");  idle_chk("add_ovf");
        run_op(2'b10, 4'b0010, 16'd300, 16'd300, "mul300");     idle_chk("mul300");
        chk("mul300.hi_const", last_e.hi, 16'h0001);
        run_op(2'b10, 4'b0011, 16'd1000, 16'd7, "div7");        idle_chk("div7");
        run_op(2'b10, 4'b0011, 16'h1234, 16'h0000, "div0");     idle_chk("div0");
        run_op(2'b10, 4'b1010, 16'h1111, 16'h2222, "illegal");  idle_chk("illegal");
        run_op(2'b01, 4'b0000, 16'd5, 16'd5, "sub_zero");       idle_chk("sub_zero");

        aluop = 2'b10; funct = 4'b0010; a = 16'd300; b = 16'd300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.result", result, 0);
        chk("abort.hi", hi, 0);
        chk("abort.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort.no_done", seen, 0);
        run_op(2'b10, 4'b0110, 16'hF0F0, 16'hFF00, "xor");      idle_chk("xor");

        run_op(2'b10, 4'b0010, 16'd123, 16'd45, "b2b_mul");
        run_op(2'b10, 4'b0100, 16'hFFFF, 16'h00FF, "b2b_and");  idle_chk("b2b_and");

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_fn = 4'($urandom);
            r_a  = W'($urandom);
            r_b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(r_op, r_fn, r_a, r_b, "rand");
            if (i % 2 == 0) idle_chk("rand");
        end
        idle_chk("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
